// File: rtl/param_bank.sv
// param_bank: captures UART parameter packets into a shadow array and commits good ones to the active array at frame start
module param_bank #(
  parameter int NUM_BYTES = 55,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_reg,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       read_data,
  input  logic             pc_ready,
  input  logic             frame_start,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             params_valid,
  output logic             swap_pulse,
  output logic             seq_error,
  output logic [7:0]       pkt_count
);
  localparam logic [IDX_W-1:0] NB = IDX_W'(NUM_BYTES);
  logic [7:0] shadow [NUM_BYTES];
  logic [7:0] active [NUM_BYTES];
  logic [IDX_W-1:0] exp_idx, exp_idx_c;
  logic bad, bad_c, pending, start, accept, good, commit;
  // completion judges the capture state including any byte arriving in the same cycle
  always_comb begin
    start = update_reg && idx == '0;
    accept = update_reg && !start && idx == exp_idx && exp_idx < NB;
    exp_idx_c = start ? IDX_W'(1) : accept ? exp_idx + 1'b1 : exp_idx;
    bad_c = start ? 1'b0 : (update_reg && !accept) ? 1'b1 : bad;
    good = pc_ready && !bad_c && exp_idx_c == NB;
    commit = frame_start && pending;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      exp_idx <= '0;
      bad <= 1'b0;
      pending <= 1'b0;
      rd_data <= '0;
      params_valid <= 1'b0;
      swap_pulse <= 1'b0;
      seq_error <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (start || accept) shadow[idx] <= read_data;
      if (commit) for (int i = 0; i < NUM_BYTES; i++) active[i] <= shadow[i];
      exp_idx <= pc_ready ? '0 : exp_idx_c;
      bad <= pc_ready | bad_c;
      pending <= good | (pending & !start & !commit);
      seq_error <= pc_ready ? !good : seq_error;
      swap_pulse <= commit;
      params_valid <= params_valid | commit;
      pkt_count <= pkt_count + {7'd0, commit};
      rd_data <= rd_addr < NB ? active[rd_addr] : '0;
    end
endmodule

// File: tb/tb_param_bank.sv
// tb_param_bank: randomized + directed scoreboard bench for param_bank against a packet-level model
module tb_param_bank;
  localparam int N = 55;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic update_reg = 1'b0, pc_ready = 1'b0, frame_start = 1'b0;
  logic [5:0] idx = '0, rd_addr = '0;
  logic [7:0] read_data = '0;
  logic [7:0] rd_data, pkt_count;
  logic params_valid, swap_pulse, seq_error;

  param_bank #(.NUM_BYTES(N), .IDX_W(6)) dut (
    .clk(clk), .reset(reset), .update_reg(update_reg), .idx(idx), .read_data(read_data),
    .pc_ready(pc_ready), .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
    .params_valid(params_valid), .swap_pulse(swap_pulse), .seq_error(seq_error), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rd;
    logic valid;
    logic swap;
    logic err;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  // packet-level model: bytes of the open packet, a snapshot of the last good one, and the displayed set
  logic [7:0] cur[$];
  bit cur_ok, cur_open, m_pend, m_valid, m_err;
  logic [7:0] m_cnt;
  logic [7:0] pend_data [N];
  logic [7:0] act [N];

  task automatic model_reset();
    cur = {};
    cur_ok = 0; cur_open = 0; m_pend = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    for (int k = 0; k < N; k++) begin
      pend_data[k] = 0;
      act[k] = 0;
    end
  endtask

  task automatic rst(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      reset = 1; update_reg = 0; pc_ready = 0; frame_start = 0; rd_addr = 6'($urandom_range(0, 63));
      model_reset();
      e = '0;
      sb.push_back(e);
    end
  endtask

  task automatic step(input bit u, input int i, input logic [7:0] d, input bit pc, input bit fs, input int ra);
    exp_t e;
    bit good;
    @(negedge clk);
    reset = 0; update_reg = u; idx = i[5:0]; read_data = d; pc_ready = pc; frame_start = fs; rd_addr = ra[5:0];
    e.rd = ra < N ? act[ra] : 8'h00;
    e.swap = fs && m_pend;
    if (e.swap) begin
      act = pend_data;
      m_pend = 0; m_valid = 1; m_cnt++;
    end
    if (u) begin
      if (i == 0) begin
        cur = {d}; cur_ok = 1; cur_open = 1; m_pend = 0;
      end else if (cur_open && cur_ok && i == cur.size() && i < N) cur.push_back(d);
      else cur_ok = 0;
    end
    if (pc) begin
      good = cur_open && cur_ok && cur.size() == N;
      if (good) begin
        m_pend = 1;
        for (int k = 0; k < N; k++) pend_data[k] = cur[k];
      end
      m_err = !good;
      cur_open = 0;
    end
    e.valid = m_valid; e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int ra);
    step(0, 0, 0, 0, 0, ra);
  endtask

  task automatic send(input int lo, input int hi, input logic [7:0] base, input bit cst);
    for (int k = lo; k <= hi; k++) step(1, k, cst ? base : 8'(base + k), 0, 0, $urandom_range(0, 63));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (rd_data !== e.rd || params_valid !== e.valid || swap_pulse !== e.swap ||
            seq_error !== e.err || pkt_count !== e.cnt) begin
          bad++;
          $display("FAIL outputs t=%0t got rd=%h valid=%b swap=%b err=%b cnt=%0d want rd=%h valid=%b swap=%b err=%b cnt=%0d",
                   $time, rd_data, params_valid, swap_pulse, seq_error, pkt_count,
                   e.rd, e.valid, e.swap, e.err, e.cnt);
        end
      end
    end
  end

  initial begin
    model_reset();
    rst(3);
    step(0, 0, 0, 1, 0, 0);
    idle(0);
    // good packet, commit, read addr 7
    send(0, 54, 8'h10, 0);
    step(0, 0, 0, 1, 0, 7);
    idle(7);
    step(0, 0, 0, 0, 1, 7);
    idle(7); idle(7); idle(55); idle(63); idle(54);
    // good packet held pending: old active visible until frame_start
    rst(2);
    send(0, 54, 8'h10, 0);
    step(0, 0, 0, 1, 0, 3);
    idle(3); idle(3);
    step(0, 0, 0, 0, 1, 3);
    idle(3); idle(3);
    // skipped index rejected, extra bytes past the end rejected
    send(0, 9, 8'h40, 0);
    send(11, 54, 8'h40, 0);
    step(0, 0, 0, 1, 0, 10);
    step(0, 0, 0, 0, 1, 10);
    idle(10);
    send(0, 54, 8'h50, 0);
    step(1, 55, 8'h99, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    idle(1);
    // packet A pending, superseded by B before frame_start
    send(0, 54, 8'hAA, 1);
    step(0, 0, 0, 1, 0, 2);
    send(0, 5, 8'h5B, 1);
    step(0, 0, 0, 0, 1, 2);
    send(6, 53, 8'h5B, 1);
    step(1, 54, 8'h5B, 1, 0, 2);
    step(0, 0, 0, 0, 1, 2);
    idle(2); idle(54);
    // pc_ready and frame_start together, then frame_start with idx 0 while pending
    send(0, 54, 8'h20, 0);
    step(0, 0, 0, 1, 1, 4);
    idle(4);
    step(1, 0, 8'hEE, 0, 1, 0);
    idle(0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    // reset mid-packet then clean packet
    send(0, 20, 8'h30, 0);
    rst(2);
    send(0, 54, 8'h30, 0);
    step(0, 0, 0, 1, 0, 9);
    step(0, 0, 0, 0, 1, 9);
    idle(9); idle(0);
    // randomized packets with glitches, stray strobes and occasional resets
    for (int p = 0; p < 45; p++) begin
      if ($urandom_range(0, 29) == 0) rst(1);
      for (int k = 0; k < N; k++) begin
        int ix;
        ix = ($urandom_range(0, 99) < 2) ? int'($urandom_range(0, 63)) : k;
        step(1, ix, 8'($urandom), $urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63));
      end
      step(0, 0, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 63));
      for (int k = $urandom_range(0, 3); k > 0; k--) step(0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 63));
    end
    idle(0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
